// File: rtl/cn_ib_rom_loader_if.sv
// Bus bundle for the CN IB-ROM page loader: load handshake, ROM read port and LUT write port.
interface cn_ib_rom_loader_if #(
    parameter int unsigned ROM_RD_BW    = 6,
    parameter int unsigned NUM_PORTS    = 2,
    parameter int unsigned ROM_ADDR_BW  = 10,
    parameter int unsigned PAGE_ADDR_BW = 5,
    parameter int unsigned ITER_ADDR_BW = 6
);
    localparam int unsigned DATA_BW = NUM_PORTS * ROM_RD_BW;

    logic                    start;
    logic                    iter_clr;
    logic [DATA_BW-1:0]      rom_dout_g0;
    logic [DATA_BW-1:0]      rom_dout_g1;
    logic                    rom_en;
    logic [ROM_ADDR_BW-1:0]  rom_addr;
    logic [DATA_BW-1:0]      wr_data;
    logic [PAGE_ADDR_BW-1:0] wr_page_addr;
    logic                    wr_en;
    logic                    busy;
    logic                    done;
    logic                    start_err;
    logic [ITER_ADDR_BW-1:0] iter_cnt;
    logic                    last_iter;

    modport master (
        output start, iter_clr, rom_dout_g0, rom_dout_g1,
        input  rom_en, rom_addr, wr_data, wr_page_addr, wr_en,
        input  busy, done, start_err, iter_cnt, last_iter
    );

    modport slave (
        input  start, iter_clr, rom_dout_g0, rom_dout_g1,
        output rom_en, rom_addr, wr_data, wr_page_addr, wr_en,
        output busy, done, start_err, iter_cnt, last_iter
    );
endinterface

// File: rtl/cn_ib_rom_loader.sv
// Streams one iteration of IB-LUT pages from the group-0/group-1 ROMs into the CN LUT,
// aligning the write strobe to the ROM read latency and counting completed iterations.
module cn_ib_rom_loader #(
    parameter int unsigned ROM_RD_BW      = 6,
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned ROM_ADDR_BW    = 10,
    parameter int unsigned PAGE_ADDR_BW   = 5,
    parameter int unsigned CN_LOAD_CYCLE  = 32,
    parameter int unsigned ITER_ROM_GROUP = 25,
    parameter int unsigned ITER_ADDR_BW   = 6,
    parameter int unsigned MAX_ITER       = 50,
    parameter int unsigned ROM_LAT        = 1
) (
    input  logic              write_clk,
    input  logic              rstn,
    cn_ib_rom_loader_if.slave bus
);
    localparam int unsigned DATA_BW  = NUM_PORTS * ROM_RD_BW;
    localparam int unsigned DRAIN_BW = $clog2(ROM_LAT + 2);

    localparam logic [PAGE_ADDR_BW-1:0] LAST_PAGE   = PAGE_ADDR_BW'(CN_LOAD_CYCLE - 1);
    localparam logic [ITER_ADDR_BW-1:0] ITER_MAX    = ITER_ADDR_BW'(MAX_ITER);
    localparam logic [ITER_ADDR_BW-1:0] ITER_GRP    = ITER_ADDR_BW'(ITER_ROM_GROUP);
    localparam logic [ROM_ADDR_BW-1:0]  PAGE_STRIDE = ROM_ADDR_BW'(CN_LOAD_CYCLE);
    localparam logic [DRAIN_BW-1:0]     DRAIN_LAST  = DRAIN_BW'(ROM_LAT);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

    state_t                  state_q, state_d;
    logic [PAGE_ADDR_BW-1:0] fetch_page_q, fetch_page_d;
    logic [DRAIN_BW-1:0]     drain_cnt_q, drain_cnt_d;
    logic [ROM_ADDR_BW-1:0]  base_q, base_d;
    logic                    grp_sel_q, grp_sel_d;
    logic [ITER_ADDR_BW-1:0] iter_cnt_q, iter_cnt_d;
    logic                    rom_en_q, rom_en_d;
    logic [ROM_ADDR_BW-1:0]  rom_addr_q, rom_addr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    start_err_q, start_err_d;

    logic [ROM_LAT-1:0]      vld_q;
    logic [PAGE_ADDR_BW-1:0] pg_q [ROM_LAT];
    logic                    wr_en_q;
    logic [PAGE_ADDR_BW-1:0] wr_page_q;
    logic [DATA_BW-1:0]      wr_data_q;

    // State and registered control outputs
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            fetch_page_q <= '0;
            drain_cnt_q  <= '0;
            base_q       <= '0;
            grp_sel_q    <= 1'b0;
            iter_cnt_q   <= '0;
            rom_en_q     <= 1'b0;
            rom_addr_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            start_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_page_q <= fetch_page_d;
            drain_cnt_q  <= drain_cnt_d;
            base_q       <= base_d;
            grp_sel_q    <= grp_sel_d;
            iter_cnt_q   <= iter_cnt_d;
            rom_en_q     <= rom_en_d;
            rom_addr_q   <= rom_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            start_err_q  <= start_err_d;
        end
    end

    // Next state; outputs are derived from the next state so they register in step with it
    always_comb begin
        state_d      = state_q;
        fetch_page_d = fetch_page_q;
        drain_cnt_d  = drain_cnt_q;
        base_d       = base_q;
        grp_sel_d    = grp_sel_q;
        iter_cnt_d   = iter_cnt_q;
        start_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (iter_cnt_q < ITER_MAX) begin
                        grp_sel_d    = (iter_cnt_q >= ITER_GRP);
                        fetch_page_d = '0;
                        state_d      = FETCH;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                start_err_d  = bus.start;
                fetch_page_d = fetch_page_q + PAGE_ADDR_BW'(1);
                if (fetch_page_q == LAST_PAGE) begin
                    drain_cnt_d = '0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                start_err_d = bus.start;
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = FIN;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_BW'(1);
                end
            end
            FIN: begin
                start_err_d = bus.start;
                iter_cnt_d  = iter_cnt_q + ITER_ADDR_BW'(1);
                base_d      = (iter_cnt_d == ITER_GRP) ? '0 : base_q + PAGE_STRIDE;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Clear/abort overrides everything, including a completing FIN
        if (bus.iter_clr) begin
            state_d     = IDLE;
            iter_cnt_d  = '0;
            base_d      = '0;
            grp_sel_d   = 1'b0;
            start_err_d = 1'b0;
        end

        rom_en_d   = (state_d == FETCH);
        rom_addr_d = rom_en_d ? base_d + ROM_ADDR_BW'(fetch_page_d) : rom_addr_q;
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FIN);
    end

    // Latency-matched valid/page pipeline and registered LUT write port
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            vld_q     <= '0;
            pg_q      <= '{default: '0};
            wr_en_q   <= 1'b0;
            wr_page_q <= '0;
            wr_data_q <= '0;
        end else begin
            vld_q    <= bus.iter_clr ? '0 : ROM_LAT'({vld_q, rom_en_q});
            pg_q[0]  <= fetch_page_q;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                pg_q[i] <= pg_q[i-1];
            end
            wr_en_q   <= vld_q[ROM_LAT-1] && !bus.iter_clr;
            wr_page_q <= pg_q[ROM_LAT-1];
            wr_data_q <= grp_sel_q ? bus.rom_dout_g1 : bus.rom_dout_g0;
        end
    end

    assign bus.rom_en       = rom_en_q;
    assign bus.rom_addr     = rom_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.wr_page_addr = wr_page_q;
    assign bus.wr_en        = wr_en_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.start_err    = start_err_q;
    assign bus.iter_cnt     = iter_cnt_q;
    assign bus.last_iter    = (iter_cnt_q == ITER_MAX);
endmodule

// File: tb/tb_cn_ib_rom_loader.sv
// Randomised bench for cn_ib_rom_loader: default instance plus a ROM_LAT=3, NUM_PORTS=4 instance,
// checked cycle by cycle against a timing/iteration model derived from the load schedule.
module tb_cn_ib_rom_loader;
    localparam int BW   = 6;
    localparam int NP   = 2;
    localparam int NPB  = 4;
    localparam int AW   = 10;
    localparam int PW   = 5;
    localparam int CN   = 32;
    localparam int GRP  = 25;
    localparam int IW   = 6;
    localparam int MAXI = 50;
    localparam int LAT  = 1;
    localparam int LATB = 3;
    localparam int DA   = NP * BW;
    localparam int DB   = NPB * BW;

    logic write_clk = 1'b0;
    logic rstn;
    int   errors = 0;
    int   checks = 0;
    int   m_iter = 0;

    always #5 write_clk = ~write_clk;

    cn_ib_rom_loader_if #(.ROM_RD_BW(BW), .NUM_PORTS(NP), .ROM_ADDR_BW(AW),
                          .PAGE_ADDR_BW(PW), .ITER_ADDR_BW(IW)) bus_a ();
    cn_ib_rom_loader_if #(.ROM_RD_BW(BW), .NUM_PORTS(NPB), .ROM_ADDR_BW(AW),
                          .PAGE_ADDR_BW(PW), .ITER_ADDR_BW(IW)) bus_b ();

    cn_ib_rom_loader #(.ROM_RD_BW(BW), .NUM_PORTS(NP), .ROM_ADDR_BW(AW), .PAGE_ADDR_BW(PW),
                       .CN_LOAD_CYCLE(CN), .ITER_ROM_GROUP(GRP), .ITER_ADDR_BW(IW),
                       .MAX_ITER(MAXI), .ROM_LAT(LAT))
        u_dut_a (.write_clk(write_clk), .rstn(rstn), .bus(bus_a.slave));

    cn_ib_rom_loader #(.ROM_RD_BW(BW), .NUM_PORTS(NPB), .ROM_ADDR_BW(AW), .PAGE_ADDR_BW(PW),
                       .CN_LOAD_CYCLE(CN), .ITER_ROM_GROUP(GRP), .ITER_ADDR_BW(IW),
                       .MAX_ITER(MAXI), .ROM_LAT(LATB))
        u_dut_b (.write_clk(write_clk), .rstn(rstn), .bus(bus_b.slave));

    task automatic step();
        @(posedge write_clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus_a.start = 1'b0; bus_a.iter_clr = 1'b0; bus_a.rom_dout_g0 = '0; bus_a.rom_dout_g1 = '0;
        bus_b.start = 1'b0; bus_b.iter_clr = 1'b0; bus_b.rom_dout_g0 = '0; bus_b.rom_dout_g1 = '0;
        repeat (3) step();
        checks++;
        if ({bus_a.rom_en, bus_a.wr_en, bus_a.busy, bus_a.done, bus_a.start_err, bus_a.last_iter} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl_a got=%b exp=000000",
                     {bus_a.rom_en, bus_a.wr_en, bus_a.busy, bus_a.done, bus_a.start_err, bus_a.last_iter});
        end
        checks++;
        if (bus_a.rom_addr !== '0 || bus_a.wr_page_addr !== '0 || bus_a.wr_data !== '0) begin
            errors++;
            $display("FAIL reset_bus_a addr=%h page=%h data=%h exp=0", bus_a.rom_addr, bus_a.wr_page_addr, bus_a.wr_data);
        end
        checks++;
        if (bus_a.iter_cnt !== '0) begin
            errors++;
            $display("FAIL reset_iter_a got=%0d exp=0", bus_a.iter_cnt);
        end
        checks++;
        if ({bus_b.rom_en, bus_b.wr_en, bus_b.busy, bus_b.done, bus_b.start_err} !== 5'b0 || bus_b.wr_data !== '0) begin
            errors++;
            $display("FAIL reset_b ctrl=%b data=%h exp=0",
                     {bus_b.rom_en, bus_b.wr_en, bus_b.busy, bus_b.done, bus_b.start_err}, bus_b.wr_data);
        end
        rstn = 1'b1;
        step();
    endtask

    // One load on instance A, started in the current cycle T; optional busy-start at T+err_at
    // and abort at T+clr_at (0 = none). Ends in the first idle cycle after the load.
    task automatic run_a(input int err_at, input int clr_at, input bit fixed,
                         input logic [DA-1:0] f0, input logic [DA-1:0] f1);
        logic [DA-1:0] rec0 [0:63];
        logic [DA-1:0] rec1 [0:63];
        logic [DA-1:0] dexp;
        int  base_e, iter_e, abort_r, nwr, nwr_e;
        bit  grp_e, live, en_e, we_e, done_e, busy_e, err_e;
        base_e  = (m_iter % GRP) * CN;
        grp_e   = (m_iter >= GRP);
        abort_r = (clr_at > 0) ? clr_at + 1 : 1000;
        nwr     = 0;
        rec0[0] = fixed ? f0 : DA'($urandom);
        rec1[0] = fixed ? f1 : DA'($urandom);
        bus_a.rom_dout_g0 = rec0[0];
        bus_a.rom_dout_g1 = rec1[0];
        bus_a.start = 1'b1;
        for (int r = 1; r <= CN + LAT + 3; r++) begin
            step();
            bus_a.start    = (r == err_at);
            bus_a.iter_clr = (r == clr_at);
            rec0[r] = fixed ? f0 : DA'($urandom);
            rec1[r] = fixed ? f1 : DA'($urandom);
            bus_a.rom_dout_g0 = rec0[r];
            bus_a.rom_dout_g1 = rec1[r];
            live   = (r < abort_r);
            en_e   = live && r <= CN;
            we_e   = live && r >= LAT + 2 && r <= LAT + 1 + CN;
            done_e = live && r == CN + LAT + 2;
            busy_e = live && r <= CN + LAT + 2;
            err_e  = (err_at > 0) && (r == err_at + 1);
            iter_e = !live ? 0 : ((r > CN + LAT + 2) ? m_iter + 1 : m_iter);
            if (bus_a.wr_en === 1'b1) nwr++;
            checks++;
            if (bus_a.rom_en !== en_e) begin
                errors++; $display("FAIL rom_en r=%0d got=%b exp=%b", r, bus_a.rom_en, en_e);
            end
            if (en_e) begin
                checks++;
                if (bus_a.rom_addr !== AW'(base_e + r - 1)) begin
                    errors++; $display("FAIL rom_addr r=%0d got=%0d exp=%0d", r, bus_a.rom_addr, base_e + r - 1);
                end
            end
            checks++;
            if (bus_a.wr_en !== we_e) begin
                errors++; $display("FAIL wr_en r=%0d got=%b exp=%b", r, bus_a.wr_en, we_e);
            end
            if (we_e) begin
                dexp = grp_e ? rec1[r-1] : rec0[r-1];
                checks++;
                if (bus_a.wr_page_addr !== PW'(r - LAT - 2) || bus_a.wr_data !== dexp) begin
                    errors++;
                    $display("FAIL wr_port r=%0d page=%0d data=%h exp page=%0d data=%h",
                             r, bus_a.wr_page_addr, bus_a.wr_data, r - LAT - 2, dexp);
                end
            end
            checks++;
            if (bus_a.done !== done_e || bus_a.busy !== busy_e || bus_a.start_err !== err_e) begin
                errors++;
                $display("FAIL hs r=%0d done/busy/err=%b%b%b exp=%b%b%b", r,
                         bus_a.done, bus_a.busy, bus_a.start_err, done_e, busy_e, err_e);
            end
            checks++;
            if (bus_a.iter_cnt !== IW'(iter_e) || bus_a.last_iter !== (iter_e == MAXI)) begin
                errors++;
                $display("FAIL iter r=%0d got=%0d last=%b exp=%0d last=%b", r,
                         bus_a.iter_cnt, bus_a.last_iter, iter_e, iter_e == MAXI);
            end
        end
        bus_a.start    = 1'b0;
        bus_a.iter_clr = 1'b0;
        nwr_e = (clr_at > 0) ? clr_at - LAT - 1 : CN;
        checks++;
        if (nwr !== nwr_e) begin
            errors++; $display("FAIL wr_count got=%0d exp=%0d", nwr, nwr_e);
        end
        m_iter = (clr_at > 0) ? 0 : m_iter + 1;
    endtask

    task automatic test_first_load();
        run_a(0, 0, 1'b0, '0, '0);
    endtask

    task automatic test_iter_clr();
        run_a(0, 20, 1'b0, '0, '0);
        run_a(0, 0, 1'b0, '0, '0);
    endtask

    task automatic test_back_to_back();
        while (m_iter < GRP) run_a(0, 0, 1'b0, '0, '0);
    endtask

    task automatic test_group1();
        logic [DA-1:0] g1;
        g1 = {6'h15, 6'h2A};
        run_a(0, 0, 1'b1, '0, g1);
    endtask

    task automatic test_start_busy();
        run_a(10, 0, 1'b0, '0, '0);
        while (m_iter < MAXI) run_a(0, 0, 1'b0, '0, '0);
    endtask

    task automatic test_max_iter();
        checks++;
        if (bus_a.last_iter !== 1'b1 || bus_a.iter_cnt !== IW'(MAXI)) begin
            errors++; $display("FAIL max_state last=%b iter=%0d exp last=1 iter=%0d", bus_a.last_iter, bus_a.iter_cnt, MAXI);
        end
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
        checks++;
        if (bus_a.start_err !== 1'b1 || bus_a.rom_en !== 1'b0 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL max_start err/en/busy=%b%b%b exp=100", bus_a.start_err, bus_a.rom_en, bus_a.busy);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus_a.start_err !== 1'b0 || bus_a.rom_en !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.iter_cnt !== IW'(MAXI)) begin
                errors++;
                $display("FAIL max_hold i=%0d err/en/busy=%b%b%b iter=%0d exp=000 %0d", i,
                         bus_a.start_err, bus_a.rom_en, bus_a.busy, bus_a.iter_cnt, MAXI);
            end
        end
    endtask

    task automatic test_lat3();
        logic [DB-1:0] rec0 [0:63];
        bit en_e, we_e, done_e;
        int nwr;
        nwr = 0;
        rec0[0] = DB'($urandom);
        bus_b.rom_dout_g0 = rec0[0];
        bus_b.rom_dout_g1 = DB'($urandom);
        bus_b.start = 1'b1;
        for (int r = 1; r <= CN + LATB + 3; r++) begin
            step();
            bus_b.start = 1'b0;
            rec0[r] = DB'($urandom);
            bus_b.rom_dout_g0 = rec0[r];
            bus_b.rom_dout_g1 = DB'($urandom);
            en_e   = (r <= CN);
            we_e   = (r >= LATB + 2) && (r <= LATB + 1 + CN);
            done_e = (r == CN + LATB + 2);
            if (bus_b.wr_en === 1'b1) nwr++;
            checks++;
            if (bus_b.rom_en !== en_e || (en_e && bus_b.rom_addr !== AW'(r - 1))) begin
                errors++; $display("FAIL b_rom r=%0d en=%b addr=%0d exp en=%b addr=%0d", r, bus_b.rom_en, bus_b.rom_addr, en_e, r - 1);
            end
            checks++;
            if (bus_b.wr_en !== we_e || bus_b.done !== done_e) begin
                errors++; $display("FAIL b_hs r=%0d wr_en=%b done=%b exp=%b %b", r, bus_b.wr_en, bus_b.done, we_e, done_e);
            end
            if (we_e) begin
                checks++;
                if (bus_b.wr_data !== rec0[r-1] || bus_b.wr_page_addr !== PW'(r - LATB - 2)) begin
                    errors++;
                    $display("FAIL b_wr r=%0d data=%h page=%0d exp data=%h page=%0d", r,
                             bus_b.wr_data, bus_b.wr_page_addr, rec0[r-1], r - LATB - 2);
                end
            end
        end
        checks++;
        if (nwr !== CN || bus_b.iter_cnt !== IW'(1) || bus_b.busy !== 1'b0) begin
            errors++; $display("FAIL b_end wr=%0d iter=%0d busy=%b exp %0d 1 0", nwr, bus_b.iter_cnt, bus_b.busy, CN);
        end
    endtask

    initial begin
        test_reset();
        test_first_load();
        test_iter_clr();
        test_back_to_back();
        test_group1();
        test_start_busy();
        test_max_iter();
        test_lat3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cn_ib_rom_loader.md
# cn_ib_rom_loader

Parametrised check-node IB-ROM page loader for the layered decoder's CN write path. On a `start` request it streams one iteration's worth of IB-LUT pages (`CN_LOAD_CYCLE` pages) from `NUM_PORTS` parallel BRAM read ports into the CN LUT memory. It selects between two iteration ROM groups and aligns the write strobe to the ROM read latency. It tracks the decoding iteration count itself and reports load completion with a start/busy/done handshake.

## Interface
- `ROM_RD_BW`, 6, bit-width of one ROM read port
- `NUM_PORTS`, 2, number of parallel ROM ports, all sharing one address
- `ROM_ADDR_BW`, 10, ROM read address width
- `PAGE_ADDR_BW`, 5, page address width; 2^PAGE_ADDR_BW ≥ CN_LOAD_CYCLE
- `CN_LOAD_CYCLE`, 32, pages per iteration
- `ITER_ROM_GROUP`, 25, iterations stored per ROM group
- `ITER_ADDR_BW`, 6, iteration counter width
- `MAX_ITER`, 50, iteration limit; must be ≤ 2*ITER_ROM_GROUP
- `ROM_LAT`, 1, ROM read latency in cycles (≥1)
- `write_clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `start`  in  1  load request pulse
- `iter_clr`  in  1  synchronous iteration clear / abort
- `rom_dout_g0`  in  NUM_PORTS*ROM_RD_BW  group-0 ROM data, port p at bits [p*ROM_RD_BW +: ROM_RD_BW]
- `rom_dout_g1`  in  NUM_PORTS*ROM_RD_BW  group-1 ROM data, same packing
- `rom_en`  out  1  ROM read enable
- `rom_addr`  out  ROM_ADDR_BW  ROM read address
- `wr_data`  out  NUM_PORTS*ROM_RD_BW  LUT write data
- `wr_page_addr`  out  PAGE_ADDR_BW  LUT write page
- `wr_en`  out  1  LUT write strobe
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle completion pulse
- `start_err`  out  1  one-cycle rejected-start pulse
- `iter_cnt`  out  ITER_ADDR_BW  completed-load count
- `last_iter`  out  1  iter_cnt == MAX_ITER

## Operation
- All outputs reset to 0. Internal state after reset: `base` = 0, `grp_sel` = 0, FSM in IDLE.
- FSM states: IDLE, FETCH, DRAIN, FIN. `busy` = (state != IDLE).
- **IDLE**
  - On `start` with `iter_cnt` < MAX_ITER: latch `grp_sel` = (iter_cnt ≥ ITER_ROM_GROUP), clear the fetch page counter, go to FETCH.
  - On `start` with `iter_cnt` == MAX_ITER: pulse `start_err`, stay in IDLE.
- **FETCH**
  - `rom_en` = 1, `rom_addr` = base + fetch_page.
  - The fetch page counter increments each cycle.
  - After page CN_LOAD_CYCLE-1 is issued, go to DRAIN.
- **DRAIN**
  - Lasts ROM_LAT+1 cycles so the pipeline empties, then go to FIN.
- **FIN**
  - `done` = 1 for one cycle; `iter_cnt` += 1.
  - If the new iter_cnt == ITER_ROM_GROUP, `base` wraps to 0; otherwise `base` += CN_LOAD_CYCLE.
  - Return to IDLE.
- **Data path**
  - A valid/page shift pipeline of depth ROM_LAT tracks each issued address.
  - `wr_data` is registered from `rom_dout_g1` when `grp_sel` is set, otherwise from `rom_dout_g0`.
  - `wr_en` and `wr_page_addr` are registered alongside `wr_data`. Pages are written in order 0..CN_LOAD_CYCLE-1.
- **Boundary behaviour**
  - `start` while busy: ignored, `start_err` pulses.
  - `iter_clr` in any state takes priority over `start` and over FIN. On the next edge: iter_cnt = 0, base = 0, grp_sel = 0, pipeline valid bits flushed, state = IDLE, with no `done` and no further `wr_en`.
  - Address width: base + page < 2^ROM_ADDR_BW for ITER_ROM_GROUP*CN_LOAD_CYCLE ≤ 2^ROM_ADDR_BW; no wrap is required inside a load.
  - `last_iter` is combinational from iter_cnt.

## Timing
- `start` sampled at edge T (cycle T is IDLE). FETCH occupies cycles T+1 .. T+CN_LOAD_CYCLE.
- The address issued in cycle k returns on rom_dout in cycle k+ROM_LAT. `wr_en` for that address is high in cycle k+ROM_LAT+1.
- First `wr_en` is at T+2+ROM_LAT; last `wr_en` is at T+1+ROM_LAT+CN_LOAD_CYCLE. `wr_en` is contiguous, with no gaps.
- DRAIN: cycles T+CN_LOAD_CYCLE+1 .. T+CN_LOAD_CYCLE+ROM_LAT+1.
- `done` is in cycle T+CN_LOAD_CYCLE+ROM_LAT+2, the cycle after the last `wr_en`. `iter_cnt` updates on the edge ending the FIN cycle.
- `busy` falls in the cycle after `done`. A new `start` is accepted in that cycle, so back-to-back loads take a period of CN_LOAD_CYCLE+ROM_LAT+3 cycles.
- `start_err` is high in the cycle after the offending `start`.

## Test plan
- Reset, then `start` with defaults → rom_addr 0..31 on cycles T+1..T+32; wr_en on T+3..T+34 with wr_page_addr 0..31; done at T+35; iter_cnt = 1; next load's rom_addr begins at 32.
- Run 25 loads, then a 26th → grp_sel = 1, rom_addr restarts at 0, wr_data follows rom_dout_g1 (drive g0 = 0, g1 = per-port 6'h2A/6'h15 → wr_data = 12'h56A).
- Run 50 loads → last_iter = 1; a further `start` → start_err pulse, no rom_en, busy stays 0.
- Pulse `start` at T+10 of an active load → start_err at T+11; load completes normally with exactly 32 wr_en.
- Assert `iter_clr` at T+20 of a load → next cycle busy = 0, iter_cnt = 0, no further wr_en, no done; a fresh `start` reads from address 0.
- ROM_LAT = 3, NUM_PORTS = 4 → first wr_en at T+5, done at T+37, all 24 data bits routed per port.
